// File: rtl/pipelined_adder.sv
// Pipelined ripple-segment adder: WIDTH-bit a + b + cin split into STAGES registered carry
// segments behind a valid/ready handshake; reports sum, carry-out and signed overflow.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG  = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic [STAGES-1:0]            advance;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
   logic                         ovf_q, ovf_d;

   // A stage may move when its slot is empty or everything downstream moves.
   always_comb begin
      logic chain;
      chain   = out_ready;
      advance = '0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         chain      = chain || !valid_q[k];
         advance[k] = chain;
      end
   end

   always_comb begin
      logic [WIDTH-1:0] src_a, src_b, src_s;
      logic             src_c, src_v;
      logic [SEG:0]     seg;
      int               p;
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      src_a   = '0;
      src_b   = '0;
      src_s   = '0;
      src_c   = 1'b0;
      src_v   = 1'b0;
      seg     = '0;
      p       = 0;
      for (int k = 0; k < int'(STAGES); k++) begin
         p = (k > 0) ? k - 1 : 0;
         if (k == 0) begin
            src_a = a;
            src_b = b;
            src_c = cin;
            src_s = '0;
            src_v = in_valid;
         end else begin
            src_a = a_q[p];
            src_b = b_q[p];
            src_c = carry_q[p];
            src_s = sum_q[p];
            src_v = valid_q[p];
         end
         seg = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, src_b[k*SEG +: SEG]}
             + {{SEG{1'b0}}, src_c};
         if (advance[k]) begin
            valid_d[k] = src_v;
            if (src_v) begin
               a_d[k]                 = src_a;
               b_d[k]                 = src_b;
               sum_d[k]               = src_s;
               sum_d[k][k*SEG +: SEG] = seg[SEG-1:0];
               carry_d[k]             = seg[SEG];
               // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
               if (k == int'(LAST)) begin
                  ovf_d = seg[SEG] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ seg[SEG-1];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   // Already-consumed operand bits are carried along for simplicity but never read.
   logic unused_ops;
   assign unused_ops = ^{a_q, b_q};

   assign in_ready  = advance[0];
   assign out_valid = valid_q[LAST];
   assign sum       = sum_q[LAST];
   assign cout      = carry_q[LAST];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: 8-bit/2-stage instance plus a 1-bit/1-stage
// half-adder instance sharing clock and reset.
module tb_pipelined_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
   logic [7:0] a = '0, b = '0, sum;
   logic       cin = 1'b0, cout, ovf;

   logic       h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_ready = 1'b1;
   logic [0:0] h_a = '0, h_b = '0, h_sum;
   logic       h_cin = 1'b0, h_cout, h_ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
      .ovf(ovf)
   );

   pipelined_adder #(.WIDTH(1), .STAGES(1)) u_half (
      .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a),
      .b(h_b), .cin(h_cin), .out_valid(h_out_valid), .out_ready(h_out_ready), .sum(h_sum),
      .cout(h_cout), .ovf(h_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h expected 00", sum); end
      n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
      n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      n_vec++; if (h_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_half_valid: got %b expected 0", h_out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      in_valid = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
      tick();
      in_valid = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
      n_vec++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'h10}) begin
         n_err++; $display("FAIL basic_result: got cout=%b ovf=%b sum=%h expected 0 0 10", cout, ovf, sum);
      end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_carry();
      logic [7:0] ta[3], tb[3], ts[3];
      logic       tc[3], tco[3], tov[3];
      ta = '{8'hFF, 8'h7F, 8'h80}; tb = '{8'h01, 8'h00, 8'h80}; tc = '{1'b0, 1'b1, 1'b0};
      ts = '{8'h00, 8'h80, 8'h00}; tco = '{1'b1, 1'b0, 1'b1}; tov = '{1'b0, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = tc[i];
         tick();
         in_valid = 1'b0;
         tick();
         n_vec++; if (out_valid !== 1'b1 || sum !== ts[i] || cout !== tco[i] || ovf !== tov[i]) begin
            n_err++;
            $display("FAIL carry_%0d: got v=%b sum=%h cout=%b ovf=%b expected 1 %h %b %b",
                     i, out_valid, sum, cout, ovf, ts[i], tco[i], tov[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa[4], ob[4], ex[4];
      logic       exp_rdy;
      int         idx, got;
      oa = '{8'h01, 8'h03, 8'h05, 8'h07}; ob = '{8'h02, 8'h04, 8'h06, 8'h08};
      ex = '{8'h03, 8'h07, 8'h0B, 8'h0F};
      idx = 0; got = 0; cin = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (idx < 4);
         if (idx < 4) begin a = oa[idx]; b = ob[idx]; end
         #1;
         if (cyc < 9) begin
            exp_rdy = (cyc < 2 || cyc >= 5);
            n_vec++; if (in_ready !== exp_rdy) begin
               n_err++; $display("FAIL bp_in_ready_c%0d: got %b expected %b", cyc, in_ready, exp_rdy);
            end
         end
         if (cyc >= 2 && cyc < 5) begin
            n_vec++; if (out_valid !== 1'b1 || sum !== 8'h03) begin
               n_err++; $display("FAIL bp_hold_c%0d: got v=%b sum=%h expected 1 03", cyc, out_valid, sum);
            end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if (got >= 4) begin
               n_err++; $display("FAIL bp_extra: got sum=%h expected no further result", sum);
            end else if (sum !== ex[got] || cyc != 5 + got) begin
               n_err++; $display("FAIL bp_out_%0d: got sum=%h at cycle %0d expected %h at cycle %0d",
                                 got, sum, cyc, ex[got], 5 + got);
            end
            got++;
         end
         if (in_valid && in_ready) idx++;
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_vec++; if (got != 4) begin n_err++; $display("FAIL bp_count: got %0d results expected 4", got); end
   endtask

   task automatic test_stream();
      logic [7:0] sa[16], sb[16];
      logic       sc[16];
      logic [8:0] full;
      logic       exp_v, exp_o;
      int         j;
      for (int i = 0; i < 16; i++) begin
         sa[i] = 8'($urandom); sb[i] = 8'($urandom); sc[i] = 1'($urandom);
      end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         in_valid = (cyc < 16);
         if (cyc < 16) begin a = sa[cyc]; b = sb[cyc]; cin = sc[cyc]; end
         #1;
         exp_v = (cyc >= 2 && cyc < 18);
         n_vec++; if (out_valid !== exp_v || in_ready !== 1'b1) begin
            n_err++; $display("FAIL stream_valid_c%0d: got v=%b rdy=%b expected %b 1",
                              cyc, out_valid, in_ready, exp_v);
         end
         if (exp_v) begin
            j = cyc - 2;
            full = {1'b0, sa[j]} + {1'b0, sb[j]} + {8'h00, sc[j]};
            exp_o = (sa[j][7] == sb[j][7]) && (full[7] != sa[j][7]);
            n_vec++; if (sum !== full[7:0] || cout !== full[8] || ovf !== exp_o) begin
               n_err++; $display("FAIL stream_%0d: got sum=%h cout=%b ovf=%b expected %h %b %b",
                                 j, sum, cout, ovf, full[7:0], full[8], exp_o);
            end
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      in_valid = 1'b1; a = 8'hF0; b = 8'h20; cin = 1'b0;
      tick();
      a = 8'h30; b = 8'h40;
      tick();
      in_valid = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b1 || sum !== 8'h10 || cout !== 1'b1) begin
         n_err++; $display("FAIL mid_pre: got v=%b sum=%h cout=%b expected 1 10 1", out_valid, sum, cout);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++; if ({out_valid, cout, ovf, sum} !== 11'h000) begin
         n_err++; $display("FAIL mid_async: got v=%b cout=%b ovf=%b sum=%h expected 0 0 0 00",
                           out_valid, cout, ovf, sum);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int cyc = 0; cyc < 4; cyc++) begin
         n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_after_c%0d: got v=%b rdy=%b expected 0 1", cyc, out_valid, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_half_adder();
      logic [3:0] ha, hb, hs, hc;
      ha = 4'b0110; hb = 4'b1100; hs = 4'b1010; hc = 4'b0100;
      h_out_ready = 1'b1; h_cin = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         h_in_valid = (cyc < 4);
         if (cyc < 4) begin h_a = ha[cyc]; h_b = hb[cyc]; end
         #1;
         n_vec++; if (h_out_valid !== (cyc >= 1)) begin
            n_err++; $display("FAIL half_valid_c%0d: got %b expected %b", cyc, h_out_valid, cyc >= 1);
         end
         if (cyc >= 1) begin
            n_vec++; if (h_sum[0] !== hs[cyc-1] || h_cout !== hc[cyc-1] || h_ovf !== hc[cyc-1]) begin
               n_err++; $display("FAIL half_%0d: got sum=%b cout=%b ovf=%b expected %b %b %b",
                                 cyc - 1, h_sum[0], h_cout, h_ovf, hs[cyc-1], hc[cyc-1], hc[cyc-1]);
            end
         end
         tick();
      end
      h_in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_back_to_back();
      test_stream();
      test_reset_mid();
      test_half_adder();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
